// File: rtl/sysarr_result_deskew.sv
// Row-result deskew for the systolic array: realigns skewed rows
// into full vectors and buffers them in a small valid/ready FIFO.
module sysarr_result_deskew #(
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] RESULTS,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] OUT,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  overflow
);

  localparam int N  = MATRIX_SIZE;
  localparam int BW = PARTIAL_SUM_BW;
  localparam int W  = N * BW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [N-2:0] vchain;
  logic         align_valid;
  logic [W-1:0] aligned;

  // valid token travels alongside the slowest row
  always_ff @(posedge clk) begin
    if (rst) begin
      vchain <= '0;
    end else begin
      vchain[0] <= in_valid;
      for (int k = 1; k < N - 1; k++)
        vchain[k] <= vchain[k-1];
    end
  end

  assign align_valid = vchain[N-2];

  for (genvar i = 0; i < N - 1; i++) begin : g_row
    localparam int D = N - 1 - i;
    logic [BW-1:0] sr [D];

    // row i is held back so it lines up with the last row
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < D; k++)
          sr[k] <= '0;
      end else begin
        sr[0] <= RESULTS[(N-1-i)*BW +: BW];
        for (int k = 1; k < D; k++)
          sr[k] <= sr[k-1];
      end
    end

    assign aligned[(N-1-i)*BW +: BW] = sr[D-1];
  end

  assign aligned[BW-1:0] = RESULTS[BW-1:0];

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign full    = fifo_count == CW'(FIFO_DEPTH);
  assign pop     = out_valid && out_ready;
  assign push_ok = align_valid && (!full || pop);
  assign drop    = align_valid && full && !pop;

  assign out_valid = fifo_count != '0;
  assign OUT       = mem[rd_ptr];

  // storage; cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++)
        mem[k] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= aligned;
    end
  end

  // pointers, occupancy and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysarr_result_deskew.sv
// Scoreboard bench for sysarr_result_deskew: a wavefront-level
// model predicts aligned vectors, FIFO occupancy and drops.
module tb_sysarr_result_deskew;

  localparam int N  = 8;
  localparam int BW = 20;
  localparam int FD = 4;
  localparam int W  = N * BW;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  RESULTS;
  logic [W-1:0]  OUT;
  logic          out_valid;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  sysarr_result_deskew #(
    .MATRIX_SIZE(N),
    .PARTIAL_SUM_BW(BW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .RESULTS(RESULTS),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUT(OUT),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           age;
    logic [W-1:0] vec;
  } wf_t;

  wf_t          pend[$];
  logic [W-1:0] sb[$];
  int           mcount = 0;
  bit           movf = 1'b0;
  bit           m_pop;
  bit           m_done;
  logic [W-1:0] m_cv;
  logic [W-1:0] m_tmp;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: each wavefront collects lane a at age a;
  // a complete vector enters a FIFO of depth FD
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      sb.delete();
      mcount = 0;
      movf = 1'b0;
    end else begin
      m_pop = (mcount > 0) && out_ready;
      m_done = 1'b0;
      if (in_valid)
        pend.push_back('{age: 0, vec: '0});
      foreach (pend[j]) begin
        m_tmp = pend[j].vec;
        m_tmp[(N-1-pend[j].age)*BW +: BW] =
          RESULTS[(N-1-pend[j].age)*BW +: BW];
        pend[j].vec = m_tmp;
        pend[j].age = pend[j].age + 1;
      end
      if (pend.size() > 0 && pend[0].age == N) begin
        m_cv = pend[0].vec;
        m_done = 1'b1;
        void'(pend.pop_front());
      end
      if (m_done) begin
        if (mcount < FD || m_pop) begin
          sb.push_back(m_cv);
          mcount++;
        end else begin
          movf = 1'b1;
        end
      end
      if (m_pop)
        mcount--;
    end
  end

  // monitor: compare head and status each cycle, pop on handshake
  always @(negedge clk) begin
    chk("out_valid", W'(out_valid), W'(mcount != 0));
    chk("fifo_count", W'(fifo_count), W'(mcount));
    chk("overflow", W'(overflow), W'(movf));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected none", OUT);
      end else begin
        chk("OUT", OUT, sb[0]);
        if (out_ready)
          void'(sb.pop_front());
      end
    end
  end

  function automatic logic [BW-1:0] val(input int mode,
                                        input int w,
                                        input int i);
    case (mode)
      0: return BW'((i + 1) * 100);
      1: begin
        case (i)
          0: return BW'(-1);
          1: return BW'(-524288);
          2: return BW'(524287);
          3: return BW'(1);
          4: return BW'(-2);
          5: return BW'(0);
          6: return BW'(12345);
          default: return BW'(-12345);
        endcase
      end
      2: return BW'(w * 16 + i);
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // nw wavefronts back-to-back from c=0; other lanes carry junk
  task automatic run(input int nw, input int mode,
                     input int rmode, input int ncyc,
                     input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      in_valid = (c < nw);
      rst = (c == rst_at);
      case (rmode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (c == N - 1);
      endcase
      for (int i = 0; i < N; i++) begin
        if (c - i >= 0 && c - i < nw)
          RESULTS[(N-1-i)*BW +: BW] = val(mode, c - i, i);
        else
          RESULTS[(N-1-i)*BW +: BW] = BW'($urandom);
      end
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    RESULTS = '0;
    repeat (3) cyc();
    chk("rst_out", OUT, '0);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_count", W'(fifo_count), '0);
    chk("rst_ovf", W'(overflow), '0);
    rst = 1'b0;

    run(1, 0, 1, N + 4, -1);
    run(1, 1, 1, N + 4, -1);
    run(4, 2, 1, 4 + N + 2, -1);

    run(4, 2, 0, 4 + N, -1);
    chk("fill_count", W'(fifo_count), W'(4));
    run(1, 3, 3, N + 2, -1);
    chk("fullpop_count", W'(fifo_count), W'(4));
    chk("fullpop_ovf", W'(overflow), '0);
    run(0, 0, 1, 8, -1);

    run(5, 2, 0, 5 + N, -1);
    chk("ovf_count", W'(fifo_count), W'(4));
    chk("ovf_set", W'(overflow), W'(1));
    run(0, 0, 0, 3, -1);
    run(0, 0, 1, 8, -1);

    run(1, 2, 1, 5, 3);
    chk("midrst_ovf", W'(overflow), '0);
    chk("midrst_count", W'(fifo_count), '0);
    chk("midrst_valid", W'(out_valid), '0);
    run(0, 0, 1, N + 2, -1);
    run(1, 0, 1, N + 4, -1);

    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      out_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++)
        RESULTS[(N-1-i)*BW +: BW] = BW'($urandom);
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    run(0, 0, 1, N + FD + 4, -1);
    chk("final_count", W'(fifo_count), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
